// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_e : clear engine states (CLEAR, READY)
//   rf_aw()    : address width for a given register count
//   RF_ZERO    : all-zero data word used by the clear engine
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Address width for a power-of-two register count.
    function automatic int unsigned rf_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RF_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: packed read ports, write ports, clear request and status.
//   master : pipeline side (drives addresses, write data, clear_req)
//   slave  : register file side (drives rd_data, init_done, wr_conflict)
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) ();
    localparam int unsigned AW = rf_aw(DEPTH);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                clear_req;
    logic                init_done;
    logic                wr_conflict;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clear_req,
        input  rd_data, init_done, wr_conflict
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clear_req,
        output rd_data, init_done, wr_conflict
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear engine: zeroes every entry after reset or a clear request, then
// reports the array valid.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   clear_req_i    : re-clear request, honoured only in READY
//   init_done_o    : registered, high once the array has been zeroed
//   clr_we_c_o     : combinational clear write strobe (high in CLEAR)
//   clr_addr_o     : registered entry index being cleared
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = rf_aw(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_req_i,
    output logic          init_done_o,
    output logic          clr_we_c_o,
    output logic [AW-1:0] clr_addr_o
);
    rf_state_e     state_q;
    logic [AW-1:0] idx_q;
    logic          init_done_q;

    // State, index and done flag; init_done rises on the edge that clears the last entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= CLEAR;
            idx_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    idx_q <= idx_q + AW'(1);
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    if (clear_req_i) begin
                        state_q     <= CLEAR;
                        idx_q       <= '0;
                        init_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= CLEAR;
                    idx_q       <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we_c_o  = (state_q == CLEAR);
    assign clr_addr_o  = idx_q;
    assign init_done_o = init_done_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with fixed-priority writes, optional
// hard-wired zero register and a sequential clear engine.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   bus (slave)   : rd_addr/rd_data (combinational reads), wr_en/wr_addr/wr_data,
//                   clear_req, init_done, wr_conflict (registered)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input logic          clk_i,
    input logic          rst_ni,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = rf_aw(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic            init_done;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            wr_ok;
    logic            conflict_c;
    logic            wr_conflict_q;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_req_i (bus.clear_req),
        .init_done_o (init_done),
        .clr_we_c_o  (clr_we),
        .clr_addr_o  (clr_addr)
    );

    // Writes are dropped while clearing and in the cycle a clear is requested.
    assign wr_ok = rst_ni && init_done && !bus.clear_req;

    // Array update; later ports assign last so the higher index wins.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_addr] <= XLEN'(RF_ZERO);
        end else if (wr_ok) begin
            for (int p = 0; p < int'(NWR); p++) begin
                if (bus.wr_en[p] &&
                    !((ZERO_REG != 0) && (bus.wr_addr[p*AW +: AW] == '0))) begin
                    mem_q[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Same-address detection between the two write ports, in any state.
    if (NWR == 2) begin : g_conflict
        assign conflict_c = bus.wr_en[0] && bus.wr_en[1] &&
                            (bus.wr_addr[0 +: AW] == bus.wr_addr[AW +: AW]);
    end else begin : g_no_conflict
        assign conflict_c = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= conflict_c;
        end
    end

    // Read ports: zero until valid, optional forwarding, zero register last.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] word;
        bus.rd_data = '0;
        ra          = '0;
        word        = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            ra   = bus.rd_addr[k*AW +: AW];
            word = '0;
            if (init_done) begin
                word = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < int'(NWR); p++) begin
                    if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == ra)) begin
                        word = bus.wr_data[p*XLEN +: XLEN];
                    end
                end
`endif
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    word = '0;
                end
            end
            bus.rd_data[k*XLEN +: XLEN] = word;
        end
    end

    assign bus.init_done   = init_done;
    assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, the next generation of the core's 2-read/1-write register file. It provides NRD combinational read ports, NWR write ports with fixed priority, a hard-wired zero register, and a sequential clear engine that zeroes the array after reset or on request. It sits between decode (read addresses) and writeback (write ports) in the pipeline, and `init_done` gates instruction issue.

## Interface
- `XLEN`, 32, data width in bits
- `DEPTH`, 32, number of registers; power of two, ≥ 4
- `NRD`, 2, number of read ports, 1..4
- `NWR`, 2, number of write ports, 1..2
- `ZERO_REG`, 1, when 1, register 0 always reads 0 and ignores writes
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset; **one clock; reset is synchronous and active-low**
- `rd_addr`  in  NRD*AW  packed read addresses; port k is bits [k*AW +: AW], where AW = log2(DEPTH)
- `rd_data`  out  NRD*XLEN  packed read data; combinational
- `wr_en`  in  NWR  per-port write enable
- `wr_addr`  in  NWR*AW  packed write addresses
- `wr_data`  in  NWR*XLEN  packed write data
- `clear_req`  in  1  single-cycle pulse requesting a full re-clear
- `init_done`  out  1  high when the array is valid and writes are accepted
- `wr_conflict`  out  1  registered flag: the previous cycle had two enabled writes to the same address

## Operation
- **FSM states:** CLEAR, READY.
- **CLEAR**
  - Writes 0 to entry `idx` each cycle, then `idx <= idx+1`.
  - When `idx == DEPTH-1`: go to READY and set `init_done <= 1` on that edge.
  - `wr_en` is ignored. `clear_req` is ignored.
- **READY**
  - Enabled writes are committed.
  - `clear_req == 1`: go to CLEAR, `idx <= 0`, `init_done <= 0`. Writes presented in that same cycle are dropped.
- **Write arbitration**
  - Two enabled ports to the same address: the higher port index wins (port 1 over port 0).
  - `wr_conflict <= 1` for one cycle. It is computed in any state, including CLEAR.
- **Zero register:** when `ZERO_REG=1`, writes to address 0 are discarded and reads of address 0 return 0. This holds in all states.
- **Reads**
  - While `init_done == 0`, every read port returns 0.
  - Otherwise a read returns the array entry, subject to the bypass rules under Configuration.
- **Address width:** addresses are exactly AW bits, so no out-of-range case exists.

## Timing
- **Reset** (rising edge with `rst_n == 0`):
  - state ← CLEAR, `idx` ← 0, `init_done` ← 0, `wr_conflict` ← 0.
  - The array itself is not reset directly; the clear engine zeroes it.
  - `rd_data` reads 0 while `init_done == 0`.
- **Clear duration:** after the first edge with `rst_n == 1`, the clear takes DEPTH cycles. `init_done` rises on the DEPTH-th edge after reset is released (edge 32 for the defaults).
- **Reset during CLEAR:** `idx` restarts at 0.
- **Reset during READY:** the whole clear runs again.
- **Read latency:** 0 cycles (combinational from `rd_addr` to `rd_data`).
- **Write latency:** the written value is visible on the read ports in the cycle after the edge that commits it.
- **`wr_conflict`:** asserted in the cycle after the conflicting writes and cleared on the following edge unless the conflict repeats.

## Configuration
- **Macro:** `REGFILE_BYPASS_EN`
- **Defined:**
  - A read whose address matches an enabled write in the same cycle, with `init_done == 1`, returns the incoming `wr_data`.
  - Priority among bypass sources matches write priority.
  - Address 0 is never bypassed when `ZERO_REG=1`.
  - Read-to-write latency is effectively 0.
- **Undefined:** a same-cycle read returns the old array value, with no forwarding logic.

## Structure
- **Package `regfile_pkg`:**
  - state enum `rf_state_e` {CLEAR, READY}
  - function `rf_aw(depth)` returning log2
  - the zero constant for XLEN
- **Sub-module `regfile_clear_fsm`:** state register, `idx` counter, `init_done`. It outputs the clear write strobe and address to the array. Arbitration, bypass and the array stay in `regfile_mp`.

## Test plan
- **Reset and clear timing:** hold `rst_n=0` for 3 cycles, then release.
  - `init_done` rises exactly 32 edges after release.
  - All reads return 0 before and after the rise.
- **Basic write/read:** in READY, write `0xDEADBEEF` to x5 on port 0.
  - Next cycle, `rd_addr` port 0 = 5 returns `0xDEADBEEF`.
  - Port 1 = 0 returns 0.
- **Write conflict:** port 0 writes `0x11111111` and port 1 writes `0x22222222` to x7 in the same cycle.
  - x7 reads `0x22222222`.
  - `wr_conflict=1` for exactly one cycle.
- **Zero register:** write `0xFFFFFFFF` to x0 → x0 still reads 0. Bypass of x0 also returns 0 when the macro is defined.
- **Bypass:** in the same cycle, write `0xCAFEF00D` to x9 and read x9.
  - With `REGFILE_BYPASS_EN`: returns `0xCAFEF00D`.
  - Without it: returns the prior value `0x00000000`.
- **Mid-operation clear:** after writing x3=`0x5A5A5A5A`, pulse `clear_req` together with a write of x4=`0x1`.
  - `init_done` drops on the next edge.
  - The x4 write is dropped.
  - 32 cycles later, `init_done=1`, x3=0 and x4=0.
